// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default 640x480@60 timing constants, raster phase encoding and
//            phase-sequencing helpers shared by the VGA timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    localparam int CNT_W         = 10;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Advance a raster phase given the counter value it is about to take.
    function automatic phase_t next_phase(input phase_t            cur,
                                          input logic [CNT_W-1:0] cnt,
                                          input logic [CNT_W-1:0] front_at,
                                          input logic [CNT_W-1:0] sync_at,
                                          input logic [CNT_W-1:0] back_at);
        phase_t nxt;
        nxt = cur;
        case (cur)
            PH_ACTIVE: if (cnt == front_at) nxt = PH_FRONT;
            PH_FRONT:  if (cnt == sync_at)  nxt = PH_SYNC;
            PH_SYNC:   if (cnt == back_at)  nxt = PH_BACK;
            PH_BACK:   if (cnt == '0)       nxt = PH_ACTIVE;
            default:                        nxt = PH_BACK;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_tick_gen
// Purpose  : Divides clk by CLK_DIV into a one-cycle pixel tick and a 50%
//            duty registered pixel clock; everything freezes while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick_en,
    output logic pixel_tick,
    output logic pixel_clk
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be even and at least 2");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // tick_en marks the edge on which the raster advances; the registered
    // pixel_tick lines up with the counters that edge produces.
    always_comb begin
        tick_en  = enable && (div_cnt == DIV_LAST);
        div_next = div_cnt;
        if (enable) begin
            div_next = tick_en ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
            pixel_clk  <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            pixel_tick <= tick_en;
            pixel_clk  <= (div_next >= DIV_HALF);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing: pixel divider, h/v counters, phase FSMs and
//            registered sync/video/pulse outputs coherent with the counters.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       pixel_clk,
    output logic       pixel_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((H_TOTAL > CNT_MAX_TOTAL) || (V_TOTAL > CNT_MAX_TOTAL)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_FRONT_AT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_AT  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_BACK_AT  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_FRONT_AT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_AT  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_BACK_AT  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic tick_en;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .tick_en    (tick_en),
        .pixel_tick (pixel_tick),
        .pixel_clk  (pixel_clk)
    );

    phase_t            h_phase;
    phase_t            v_phase;
    phase_t            h_phase_next;
    phase_t            v_phase_next;
    logic [CNT_W-1:0]  h_next;
    logic [CNT_W-1:0]  v_next;
    logic              h_sync_next;
    logic              v_sync_next;
    logic              video_next;
    logic              line_next;
    logic              frame_next;

    // Outputs are decoded from the next counter/phase values so that they are
    // registered on the same edge as the counters and never lag them.
    always_comb begin
        h_next       = h_count;
        v_next       = v_count;
        h_phase_next = h_phase;
        v_phase_next = v_phase;
        if (tick_en) begin
            if (h_count == H_LAST) begin
                h_next       = '0;
                v_next       = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
                v_phase_next = next_phase(v_phase, v_next, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
            end else begin
                h_next = h_count + CNT_W'(1);
            end
            h_phase_next = next_phase(h_phase, h_next, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
        end

        h_sync_next = (h_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        v_sync_next = (v_phase_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_next  = (h_next < H_FRONT_AT) && (v_next < V_FRONT_AT);
        line_next   = tick_en && (h_next == '0);
        frame_next  = line_next && (v_next == '0);
    end

    // Reset parks the raster on the last pixel of the last line so the very
    // first tick wraps to the origin and announces a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            h_phase     <= PH_BACK;
            v_phase     <= PH_BACK;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            h_phase     <= h_phase_next;
            v_phase     <= v_phase_next;
            h_sync      <= h_sync_next;
            v_sync      <= v_sync_next;
            video_on    <= video_next;
            line_start  <= line_next;
            frame_start <= frame_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench: default 640x480 instance plus a shrunken
//            active-high-sync, divide-by-4 instance sharing clk/rst/enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       pclk  [2];
    logic       ptick [2];
    logic       hs    [2];
    logic       vs    [2];
    logic       von   [2];
    logic       ls    [2];
    logic       fs    [2];
    logic [9:0] hc    [2];
    logic [9:0] vc    [2];

    exp_t q0[$];
    exp_t q1[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cnt[2];
    int   last_ls = -1;
    int   last_fs = -1;
    bit   ls_done = 1'b0;
    bit   fs_done = 1'b0;
    logic en_q;

    vga_timing_gen dut0 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pixel_clk   (pclk[0]),
        .pixel_tick  (ptick[0]),
        .h_sync      (hs[0]),
        .v_sync      (vs[0]),
        .h_count     (hc[0]),
        .v_count     (vc[0]),
        .video_on    (von[0]),
        .line_start  (ls[0]),
        .frame_start (fs[0])
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV  (4), .SYNC_POL (1'b1)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pixel_clk   (pclk[1]),
        .pixel_tick  (ptick[1]),
        .h_sync      (hs[1]),
        .v_sync      (vs[1]),
        .h_count     (hc[1]),
        .v_count     (vc[1]),
        .video_on    (von[1]),
        .line_start  (ls[1]),
        .frame_start (fs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) en_q <= enable;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected raster record at position (h,v); ranges written out by hand.
    function automatic exp_t mk(input int d, input int h, input int v);
        exp_t e;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        if (d == 0) begin
            e.hs  = !(h >= 656 && h <= 751);
            e.vs  = !(v >= 490 && v <= 491);
            e.von = (h < 640) && (v < 480);
        end else begin
            e.hs  = (h >= 10 && h <= 12);
            e.vs  = (v >= 7 && v <= 8);
            e.von = (h < 8) && (v < 6);
        end
        return e;
    endfunction

    task automatic push_seq(input int n0, input int n1);
        int h;
        int v;
        h = 799; v = 524;
        for (int i = 0; i < n0; i++) begin
            h++;
            if (h == 800) begin h = 0; v++; if (v == 525) v = 0; end
            q0.push_back(mk(0, h, v));
        end
        h = 14; v = 9;
        for (int i = 0; i < n1; i++) begin
            h++;
            if (h == 15) begin h = 0; v++; if (v == 10) v = 0; end
            q1.push_back(mk(1, h, v));
        end
    endtask

    task automatic check_reset();
        chk("reset_dut0", 32'({hc[0], vc[0], hs[0], vs[0], von[0], ls[0], fs[0], ptick[0], pclk[0]}),
            32'({10'd799, 10'd524, 2'b11, 5'b00000}));
        chk("reset_dut1", 32'({hc[1], vc[1], hs[1], vs[1], von[1], ls[1], fs[1], ptick[1], pclk[1]}),
            32'({10'd14, 10'd9, 2'b00, 5'b00000}));
    endtask

    task automatic check_tick(input int d);
        exp_t got;
        exp_t e;
        got = {hc[d], vc[d], hs[d], vs[d], von[d], ls[d], fs[d]};
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_tick dut%0d got=%h want=none", d, got);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk((d == 0) ? "raster_dut0" : "raster_dut1", 32'(got), 32'(e));
        end
        if (d == 0 && ls[0]) begin
            if (last_ls >= 0 && !ls_done) begin
                chk("line_period_dut0", 32'(cyc - last_ls), 32'd1600);
                ls_done = 1'b1;
            end
            last_ls = cyc;
        end
        if (d == 1 && fs[1]) begin
            if (last_fs >= 0 && !fs_done) begin
                chk("frame_period_dut1", 32'(cyc - last_fs), 32'd600);
                fs_done = 1'b1;
            end
            last_fs = cyc;
        end
    endtask

    // Monitor: en_q is the enable each DUT saw at the preceding edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            cnt[0] = 0;
            cnt[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!en_q) begin
                    chk("tick_while_disabled", 32'(ptick[d]), 32'd0);
                end else if (ptick[d]) begin
                    chk("tick_spacing", 32'(cnt[d] + 1), (d == 0) ? 32'd2 : 32'd4);
                    cnt[d] = 0;
                    check_tick(d);
                end else begin
                    cnt[d]++;
                end
                chk("pixel_clk", 32'(pclk[d]), 32'(cnt[d] >= ((d == 0) ? 1 : 2)));
                if (!ptick[d]) chk("pulse_idle", 32'({ls[d], fs[d]}), 32'd0);
            end
        end
    end

    task automatic wait_pos(input int v, input int h);
        int n;
        n = 0;
        while (!(vc[0] == 10'(v) && hc[0] == 10'(h)) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pos", 32'({vc[0], hc[0]}), 32'({10'(v), 10'(h)}));
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        cnt[0] = 0;
        cnt[1] = 0;
        repeat (3) @(negedge clk);
        check_reset();
        push_seq(2000, 1000);
        #2 rst = 1'b1;

        // Freeze for 50 clk in line 1 at h=300.
        wait_pos(1, 300);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        chk("hold_pos", 32'({vc[0], hc[0]}), 32'({10'd1, 10'd300}));
        enable = 1'b1;

        // Asynchronous reset mid-line.
        wait_pos(1, 700);
        #2 rst = 1'b0;
        #1 check_reset();
        repeat (3) begin
            @(negedge clk);
            chk("pulse_in_reset", 32'({ls[0], fs[0], ls[1], fs[1]}), 32'd0);
        end
        q0.delete();
        q1.delete();
        push_seq(20, 10);
        #2 rst = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_dut0", 32'(q0.size()), 32'd0);
        chk("drain_dut1", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the sprite control path: generates the pixel clock, horizontal/vertical sync and the raster counters consumed by the horizontal pixel counter and the sprite position finder.
- Implements standard 640x480@60 Hz VGA timing from the 50 MHz system clock.
- All raster state advances on a single-cycle pixel tick enable; `pixel_clk` is also exported as a registered square wave for stages clocked by it.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; even, >=2
- SYNC_POL, 0, asserted level of `h_sync`/`v_sync` (0 = active-low)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = run; 0 = freeze divider, counters and outputs
- pixel_clk  out  1  registered clock, clk/CLK_DIV, 50% duty
- pixel_tick  out  1  one-clk pulse per pixel
- h_sync  out  1  horizontal sync, level per SYNC_POL
- v_sync  out  1  vertical sync, level per SYNC_POL
- h_count  out  10  pixel index, 0..H_TOTAL-1
- v_count  out  10  line index, 0..V_TOTAL-1
- video_on  out  1  1 when h_count<H_ACTIVE and v_count<V_ACTIVE
- line_start  out  1  one-clk pulse when h_count becomes 0
- frame_start  out  1  one-clk pulse when h_count and v_count both become 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset values (asynchronous, while `rst`=0):
  - div_cnt = 0, `pixel_clk` = 0, `pixel_tick` = 0
  - `h_count` = H_TOTAL-1, `v_count` = V_TOTAL-1
  - h_phase = H_BP, v_phase = V_BP
  - `h_sync`/`v_sync` inactive (= ~SYNC_POL)
  - `video_on` = 0, `line_start` = 0, `frame_start` = 0
  - Consequence: the first tick after reset wraps to (0,0) and pulses `frame_start`.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while `enable`=1.
  - `pixel_tick` is registered high on the clk where div_cnt==CLK_DIV-1, otherwise 0.
  - `pixel_clk` register = (div_cnt >= CLK_DIV/2) after the update.
- On each tick (the edge where div_cnt wraps):
  - `h_count` increments; at H_TOTAL-1 it wraps to 0 and `v_count` increments.
  - `v_count` wraps from V_TOTAL-1 to 0.
- Phase FSMs, updated on the same edge as the counters:
  - Horizontal: ACTIVE -> FRONT at h=H_ACTIVE, FRONT -> SYNC at H_ACTIVE+H_FP, SYNC -> BACK at H_ACTIVE+H_FP+H_SYNC, BACK -> ACTIVE at 0.
  - Vertical: identical structure on `v_count`, transitions only on line wrap.
  - Unused/illegal encoding recovers to BACK.
- Output decode:
  - All outputs are registered and coherent with `h_count`/`v_count` in the same cycle (zero-latency decode of next state).
  - `h_sync` = SYNC_POL while h_phase==SYNC (h 656..751); `v_sync` = SYNC_POL while v_phase==SYNC (v 490..491); else ~SYNC_POL.
  - `line_start` and `frame_start` are high exactly on the clk where the counters become 0, and low the next clk.
- `enable`=0:
  - div_cnt, counters and phases hold; `pixel_tick` = 0; pulse outputs forced 0; `pixel_clk` holds.
  - Resuming continues from the held position; no tick is lost or duplicated.
- Reset mid-line or mid-frame: immediate return to reset values; no glitch pulse on `line_start`/`frame_start` while in reset.
- Width: 10-bit counters cover up to 1023; parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported (elaboration-time assertion).

Decomposition:
- Package vga_timing_pkg: default timing constants, H_TOTAL/V_TOTAL derivation, phase encodings (ACTIVE, FRONT, SYNC, BACK, 2 bits).
- One sub-module: pixel_tick_gen (divider producing `pixel_tick` and `pixel_clk`, with `enable`).
- Counters, phase FSMs and output decode stay in vga_timing_gen.

Test Plan:
- Release reset, `enable`=1, CLK_DIV=2 -> `pixel_tick` every 2nd clk; first tick gives h=0, v=0, `frame_start`=1, `line_start`=1, `video_on`=1.
- Run one line -> `h_sync` low for exactly 96 ticks (192 clk) starting at h=656; `video_on` falls at h=640; `line_start` period 1600 clk.
- Run one full frame -> `v_sync` low during v=490..491 only; `frame_start` period 420000 ticks (840000 clk); `v_count` wraps 524->0.
- Drop `enable` at h=300 for 50 clk -> counters hold at 300, no `pixel_tick`; on resume next tick gives h=301.
- Assert `rst` at h=700, v=100 -> immediately h=799, v=524, syncs high, `video_on`=0; after release, first tick pulses `frame_start`.
- SYNC_POL=1, CLK_DIV=4 -> syncs active-high at the same positions; `pixel_tick` every 4 clk; `pixel_clk` high 2 clk, low 2 clk.
